// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared FSM state type and serial line levels for serial_frame_tx.
package serial_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;
endpackage

// File: rtl/bit_period_timer.sv
// bit_period_timer: divides Clk into bit periods of BIT_CYCLES clocks.
//   Clk     in  clock
//   Rst_l   in  asynchronous active-low reset
//   restart in  forces the count to 0 on the next edge (new frame begins)
//   tick    out high in the last cycle of each period
module bit_period_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic Clk,
    input  logic Rst_l,
    input  logic restart,
    output logic tick
);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    logic [CW-1:0] count_q, count_d;
    assign tick    = count_q == CW'(BIT_CYCLES - 1);
    assign count_d = (restart || tick) ? '0 : count_q + CW'(1);
    always_ff @(posedge Clk or negedge Rst_l) begin
        if (!Rst_l) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: buffered parallel-to-serial frame transmitter (start, data MSB first, optional even parity, stop).
//   Clk, Rst_l  clock, asynchronous active-low reset
//   In_Data     word to transmit, captured on In_Valid && In_Ready
//   In_Valid    In_Data valid
//   In_Ready    one-entry buffer is empty
//   Serial_Tx   registered serial line, idle 0
//   Bit_Strobe  first cycle of every bit period
//   Busy        frame on the line
//   Frame_Done  last cycle of the stop bit
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 1,
    parameter bit PARITY_EN  = 1
) (
    input  logic              Clk,
    input  logic              Rst_l,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic              Serial_Tx,
    output logic              Bit_Strobe,
    output logic              Busy,
    output logic              Frame_Done
);
    localparam int BW = $clog2(DATA_W + 1);
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d, shift_q, shift_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic              par_q, par_d, rdy_q, rdy_d;
    logic              tx_q, tx_d, busy_q, busy_d, strb_q, strb_d;
    logic              load, tick, accept;

    bit_period_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .Clk     (Clk),
        .Rst_l   (Rst_l),
        .restart (load),
        .tick    (tick)
    );

    // A buffered word starts a frame from IDLE or straight out of the last stop cycle.
    assign load   = !rdy_q && (state_q == IDLE || (state_q == STOP && tick));
    assign accept = In_Valid && rdy_q;
    assign rdy_d  = load ? 1'b1 : accept ? 1'b0 : rdy_q;
    assign buf_d  = accept ? In_Data : buf_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        case (state_q)
            START:   if (tick) state_d = DATA;
            DATA: if (tick) begin
                shift_d  = shift_q << 1;
                bitcnt_d = bitcnt_q + BW'(1);
                if (bitcnt_q == BW'(DATA_W - 1)) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = state_q;
        endcase
        if (load) begin
            state_d  = START;
            shift_d  = buf_q;
            bitcnt_d = '0;
            par_d    = ^buf_q;
        end
        // Outputs are registered, so they are computed from the next state.
        tx_d   = state_d == START  ? LINE_START :
                 state_d == DATA   ? shift_d[DATA_W-1] :
                 state_d == PARITY ? par_d :
                 state_d == STOP   ? LINE_STOP : LINE_IDLE;
        busy_d = state_d != IDLE;
        strb_d = busy_d && (tick || state_q == IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_l) begin
        if (!Rst_l) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            rdy_q    <= 1'b1;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            strb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            rdy_q    <= rdy_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            strb_q   <= strb_d;
        end
    end

    assign In_Ready   = rdy_q;
    assign Serial_Tx  = tx_q;
    assign Busy       = busy_q;
    assign Bit_Strobe = strb_q;
    // Decoded purely from flops: stop state in the final cycle of its period.
    assign Frame_Done = state_q == STOP && tick;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx across default, slow-bit and no-parity configurations.
module tb_serial_frame_tx;
    logic       Clk = 1'b0;
    logic       Rst_l = 1'b0;
    logic [3:0] din [3];
    logic [2:0] vld;
    logic [2:0] rdy, tx, strb, busy, done;

    always #5 Clk = ~Clk;

    serial_frame_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_EN(1)) u0 (
        .Clk(Clk), .Rst_l(Rst_l), .In_Data(din[0]), .In_Valid(vld[0]), .In_Ready(rdy[0]),
        .Serial_Tx(tx[0]), .Bit_Strobe(strb[0]), .Busy(busy[0]), .Frame_Done(done[0]));
    serial_frame_tx #(.DATA_W(4), .BIT_CYCLES(3), .PARITY_EN(1)) u3 (
        .Clk(Clk), .Rst_l(Rst_l), .In_Data(din[1]), .In_Valid(vld[1]), .In_Ready(rdy[1]),
        .Serial_Tx(tx[1]), .Bit_Strobe(strb[1]), .Busy(busy[1]), .Frame_Done(done[1]));
    serial_frame_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_EN(0)) up (
        .Clk(Clk), .Rst_l(Rst_l), .In_Data(din[2]), .In_Valid(vld[2]), .In_Ready(rdy[2]),
        .Serial_Tx(tx[2]), .Bit_Strobe(strb[2]), .Busy(busy[2]), .Frame_Done(done[2]));

    typedef struct packed {
        logic tx;
        logic strb;
        logic busy;
        logic done;
        logic first;
    } ent_t;

    ent_t sb[$];
    bit   mfull;
    int   checks = 0;
    int   errors = 0;

    function automatic int bc_of(input int d);
        return d == 1 ? 3 : 1;
    endfunction

    // Expand one word into its per-cycle expected line behaviour.
    task automatic push_frame(input int d, input logic [3:0] w);
        logic bits[$];
        int   bc;
        bc = bc_of(d);
        bits.push_back(1'b1);
        for (int i = 3; i >= 0; i--) bits.push_back(w[i]);
        if (d != 2) bits.push_back(^w);
        bits.push_back(1'b0);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < bc; c++)
                sb.push_back('{tx: bits[b], strb: c == 0, busy: 1'b1,
                               done: (b == bits.size() - 1) && (c == bc - 1),
                               first: (b == 0) && (c == 0)});
    endtask

    // One clock: model the handshake from the bench's own buffer state, then check the cycle.
    task automatic step(input int d, output bit hs);
        ent_t e;
        hs = vld[d] && !mfull;
        @(posedge Clk);
        if (hs) begin
            if (sb.size() == 0) sb.push_back('0);
            push_frame(d, din[d]);
            mfull = 1'b1;
        end
        @(negedge Clk);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        if (e.first) mfull = 1'b0;
        checks += 5;
        if (tx[d] !== e.tx) begin
            errors++;
            $display("FAIL tx dut%0d t=%0t got %b want %b", d, $time, tx[d], e.tx);
        end
        if (strb[d] !== e.strb) begin
            errors++;
            $display("FAIL strobe dut%0d t=%0t got %b want %b", d, $time, strb[d], e.strb);
        end
        if (busy[d] !== e.busy) begin
            errors++;
            $display("FAIL busy dut%0d t=%0t got %b want %b", d, $time, busy[d], e.busy);
        end
        if (done[d] !== e.done) begin
            errors++;
            $display("FAIL frame_done dut%0d t=%0t got %b want %b", d, $time, done[d], e.done);
        end
        if (rdy[d] !== !mfull) begin
            errors++;
            $display("FAIL in_ready dut%0d t=%0t got %b want %b", d, $time, rdy[d], !mfull);
        end
    endtask

    task automatic run(input int d, input int n);
        bit hs;
        repeat (n) step(d, hs);
    endtask

    task automatic wait_hs(input int d);
        bit hs = 1'b0;
        for (int i = 0; i < 30 && !hs; i++) step(d, hs);
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL handshake dut%0d got none want accept within 30 cycles", d);
        end
    endtask

    task automatic send(input int d, input logic [3:0] w);
        din[d] = w;
        vld[d] = 1'b1;
        wait_hs(d);
        vld[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        bit hs;
        for (int i = 0; i < 80 && sb.size() > 0; i++) step(d, hs);
        run(d, 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain dut%0d got %0d pending cycles want 0", d, sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 5;
        if (tx !== 3'b000) begin errors++; $display("FAIL %s tx got %b want 000", tag, tx); end
        if (rdy !== 3'b111) begin errors++; $display("FAIL %s in_ready got %b want 111", tag, rdy); end
        if (busy !== 3'b000) begin errors++; $display("FAIL %s busy got %b want 000", tag, busy); end
        if (strb !== 3'b000) begin errors++; $display("FAIL %s strobe got %b want 000", tag, strb); end
        if (done !== 3'b000) begin errors++; $display("FAIL %s frame_done got %b want 000", tag, done); end
    endtask

    task automatic test_reset;
        Rst_l = 1'b0;
        vld = '0;
        for (int i = 0; i < 3; i++) din[i] = 4'h0;
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Rst_l = 1'b1;
        sb.delete();
        mfull = 1'b0;
        run(0, 10);
    endtask

    task automatic test_single;
        send(0, 4'b1011);
        drain(0);
    endtask

    task automatic test_back_to_back;
        send(0, 4'hA);
        send(0, 4'h6);
        drain(0);
    endtask

    task automatic test_slow_bits;
        send(1, 4'h0);
        drain(1);
    endtask

    task automatic test_reset_mid_frame;
        send(0, 4'h7);
        send(0, 4'h9);
        run(0, 2);
        #2 Rst_l = 1'b0;
        #1 check_reset_outputs("async_reset");
        sb.delete();
        mfull = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_l = 1'b1;
        run(0, 12);
        send(0, 4'hF);
        drain(0);
    endtask

    task automatic test_hold_valid;
        din[2] = 4'hC;
        vld[2] = 1'b1;
        wait_hs(2);
        din[2] = 4'h3;
        wait_hs(2);
        vld[2] = 1'b0;
        drain(2);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_slow_bits;
        test_reset_mid_frame;
        test_hold_valid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
